// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter in front of a single-ported data memory. The CPU load/store
//   port and the debug/loader port share one memory. The arbitration decision is
//   combinational on the current requests and is registered into the state. The
//   winning access then owns the memory for the following cycle.
//
//   Build option: ARB_ROUND_ROBIN_EN
//     defined   -> a contention tie goes to the requester that was not served last
//     undefined -> a contention tie always goes to the CPU (fixed priority)
//   In both builds a requester that has waited STARVE_MAX cycles is forced to win.
//
// Ports
//   clk, rst                                   clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata                      CPU request (held until granted)
//   cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall  CPU grant, read return and stall
//   dbg_req/we/addr/wdata, dbg_lock            debug request; lock keeps bursts
//   dbg_gnt, dbg_rvalid, dbg_rdata             debug grant and read return
//   mem_wr_rd_en, mem_addr, mem_wdata          memory command (registered)
//   mem_rdata                                  memory combinational read data
module dmem_arbiter #(
  parameter int         DATA_W     = 32,
  parameter logic [3:0] STARVE_MAX = 4'd15
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [DATA_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic              mem_wr_rd_en,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // State names the owner of the memory in the current cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DBG_ACC = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cpu_wait, dbg_wait;
  logic       cpu_starved, dbg_starved;
  logic       tie_cpu_wins;

  assign cpu_starved = (cpu_wait == STARVE_MAX);
  assign dbg_starved = (dbg_wait == STARVE_MAX);

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who won the last grant; resets to DBG so the CPU wins the first tie.
  logic rr_last_dbg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      rr_last_dbg <= 1'b1;
    else if (state_nxt == CPU_ACC) rr_last_dbg <= 1'b0;
    else if (state_nxt == DBG_ACC) rr_last_dbg <= 1'b1;
  end

  assign tie_cpu_wins = rr_last_dbg;
`else
  assign tie_cpu_wins = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state arbitration
  always_comb begin
    state_nxt = IDLE;
    if (cpu_req && dbg_req) begin
      if (state == DBG_ACC && dbg_lock)
        // A locked debug burst keeps the memory unless the CPU is starving.
        state_nxt = cpu_starved ? CPU_ACC : DBG_ACC;
      else if (cpu_starved && !dbg_starved)
        state_nxt = CPU_ACC;
      else if (dbg_starved && !cpu_starved)
        state_nxt = DBG_ACC;
      else
        state_nxt = tie_cpu_wins ? CPU_ACC : DBG_ACC;
    end else if (cpu_req) begin
      state_nxt = CPU_ACC;
    end else if (dbg_req) begin
      state_nxt = DBG_ACC;
    end
  end

  // Wait counters. They clear on the edge that issues the grant rather than
  // during the grant cycle. Otherwise a starved port would still show
  // STARVE_MAX at the next decision and win twice in a row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 cpu_wait <= 4'd0;
    else if (!cpu_req || state_nxt == CPU_ACC) cpu_wait <= 4'd0;
    else if (!cpu_starved)                    cpu_wait <= cpu_wait + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 dbg_wait <= 4'd0;
    else if (!dbg_req || state_nxt == DBG_ACC) dbg_wait <= 4'd0;
    else if (!dbg_starved)                    dbg_wait <= dbg_wait + 4'd1;
  end

  // Memory command. It is loaded from the winner on the decision edge. The
  // address and write data hold their values through IDLE cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wr_rd_en <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      case (state_nxt)
        CPU_ACC: begin
          mem_wr_rd_en <= cpu_we;
          mem_addr     <= cpu_addr;
          mem_wdata    <= cpu_wdata;
        end
        DBG_ACC: begin
          mem_wr_rd_en <= dbg_we;
          mem_addr     <= dbg_addr;
          mem_wdata    <= dbg_wdata;
        end
        default: mem_wr_rd_en <= 1'b0;
      endcase
    end
  end

  // Grants are decoded from the registered owner, so each grant is one cycle
  // per access.
  assign cpu_gnt   = (state == CPU_ACC);
  assign dbg_gnt   = (state == DBG_ACC);
  assign cpu_stall = cpu_req && !cpu_gnt;

  // Read return. mem_rdata is captured at the end of the owner's read cycle,
  // and rvalid pulses in the cycle after that. The non-owner's rdata holds.
  logic cpu_rd_now, dbg_rd_now;
  assign cpu_rd_now = cpu_gnt && !mem_wr_rd_en;
  assign dbg_rd_now = dbg_gnt && !mem_wr_rd_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_rd_now;
      dbg_rvalid <= dbg_rd_now;
      if (cpu_rd_now) cpu_rdata <= mem_rdata;
      if (dbg_rd_now) dbg_rdata <= mem_rdata;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: width of address and data buses.
REQ-002 Parameter STARVE_MAX, default 4'd15: wait cycles after which a pending requester is forced to win.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous reset, active-low; 0 clears all state immediately.
REQ-005 cpu_req  input  1  CPU load/store request; held high until granted.
REQ-006 cpu_we  input  1  1 = write, 0 = read.
REQ-007 cpu_addr, cpu_wdata  input  DATA_W  CPU address and write data, stable while cpu_req is high.
REQ-008 cpu_gnt  output  1  CPU request accepted this cycle.
REQ-009 cpu_rvalid  output  1  CPU read data valid; one-cycle pulse.
REQ-010 cpu_rdata  output  DATA_W  CPU read data.
REQ-011 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: debug/loader port with the same widths and meanings as REQ-005..REQ-010.
REQ-012 dbg_lock  input  1  while high with dbg_req, the debug port keeps the grant on back-to-back cycles.
REQ-013 mem_wr_rd_en  output  1  data memory write enable.
REQ-014 mem_addr, mem_wdata  output  DATA_W  data memory address and write data.
REQ-015 mem_rdata  input  DATA_W  data memory combinational read data.
REQ-016 cpu_stall  output  1  high when cpu_req is high and cpu_gnt is low.

Function
REQ-017 FSM states: IDLE, CPU_ACC, DBG_ACC; the state register holds the owner of the current access cycle.
REQ-018 Arbitration is combinational on the current requests and the registered state; the grant is registered, so an access occupies the memory in the cycle after the grant decision.
REQ-019 From any state: no request -> IDLE; a single request -> that requester's ACC state.
REQ-020 Both requesting: a requester whose wait counter equals STARVE_MAX wins; otherwise the Configuration policy decides.
REQ-021 In DBG_ACC with dbg_lock=1 and dbg_req=1: stay in DBG_ACC regardless of cpu_req, unless the CPU wait counter equals STARVE_MAX.
REQ-022 In an ACC state: drive mem_addr/mem_wdata from the owner, set mem_wr_rd_en = owner_we, and assert the owner's gnt for exactly that cycle.
REQ-023 In IDLE: mem_wr_rd_en=0; mem_addr and mem_wdata hold their last values.
REQ-024 Read in an ACC state: capture mem_rdata at the end of the cycle into the owner's rdata register, and pulse the owner's rvalid on the next cycle (read latency 1 cycle after gnt).
REQ-025 Write: rvalid is not asserted.
REQ-026 The non-owner's rdata holds its value.
REQ-027 Each port has a 4-bit wait counter: increments while req=1 and gnt=0, saturates at STARVE_MAX, and clears on gnt or when req=0.
REQ-028 A requester that drops req before being granted is not serviced, and no rvalid is produced for it.
REQ-029 Back-to-back grants to the same or alternating requesters are legal every cycle; the arbiter inserts no idle cycles.
REQ-030 The same-cycle gnt and rvalid of different ports are independent and may both be high.

Reset
REQ-031 When rst=0: state=IDLE, cpu_gnt=dbg_gnt=0, cpu_rvalid=dbg_rvalid=0, cpu_rdata=dbg_rdata=0, mem_wr_rd_en=0, mem_addr=mem_wdata=0, wait counters=0, and the round-robin pointer points at DBG (CPU wins first).
REQ-032 Reset asserted mid-access aborts the access; no rvalid is issued after deassertion.
REQ-033 The first grant occurs on the first rising edge after rst rises, if a request is present.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN defined: on a contention tie, the requester not served last wins, and the pointer updates on every grant.
REQ-035 Macro ARB_ROUND_ROBIN_EN undefined: on a contention tie, the CPU always wins (fixed priority); the starvation rule REQ-020 still applies, and the pointer logic is not compiled.

Verification
REQ-036 Reset: hold rst=0 with both requests high -> all outputs 0; release -> cpu_gnt=1 on the first edge, dbg_gnt=0.
REQ-037 CPU read: cpu_req=1, cpu_we=0, cpu_addr=0x10, mem_rdata=0xCAFEF00D -> cpu_gnt for 1 cycle, cpu_rvalid the next cycle, cpu_rdata=0xCAFEF00D.
REQ-038 Contention with ARB_ROUND_ROBIN_EN and both requests held high for 6 cycles -> grants alternate CPU, DBG, CPU, DBG, CPU, DBG.
REQ-039 Fixed priority with cpu_req held high and dbg_req held high -> dbg_gnt=1 on cycle 16 (counter reaches 15), then CPU resumes.
REQ-040 Lock: dbg_lock=1 with a 3-write dbg burst to 0x0,0x4,0x8 while cpu_req=1 -> three consecutive dbg_gnt with mem_wr_rd_en=1, cpu_stall=1 throughout, then cpu_gnt.
REQ-041 Mid-read reset: assert rst=0 during a dbg read grant -> dbg_rvalid stays 0 and dbg_rdata=0 after release.
